// File: rtl/edge_arb_pkg.sv
// Shared definitions for the edge event arbiter: controller state encoding and channel limits.
package edge_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int N_MAX = 16;

endpackage

// File: rtl/edge_detect.sv
// One-bit Mealy rising-edge detector; e is combinational from w and the previous sample.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic w,
  output logic e
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= w;
  end

  assign e = w & ~prev_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Latches rising edges from N level inputs and serves them one at a time to a single
// consumer through a round-robin grant/ack handshake with sticky overrun flags.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    w,
  input  logic            ack,
  input  logic            clr_ovr,
  output logic            grant_valid,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    overrun
);

  arb_state_e      state_q, state_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    overrun_q, overrun_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic            grant_valid_q, grant_valid_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]    edge_s;
  logic [N-1:0]    clr_s;
  logic [ID_W-1:0] pick_s;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_edge
      edge_detect u_edge_detect (
        .clk   (clk),
        .reset (reset),
        .w     (w[gi]),
        .e     (edge_s[gi])
      );
    end
  endgenerate

  // First requester at or after start, wrapping modulo N.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] req,
                                               input logic [ID_W-1:0] start);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start) + k) % N;
      if (!found && req[idx]) begin
        pick  = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign clr_s  = (state_q == GRANT && ack) ? grant_q : '0;
  assign pick_s = rr_pick(pending_q, ptr_q);

  // A fresh edge always re-arms pending; it only counts as overrun if it was not just served.
  always_comb begin
    pending_d = edge_s | (pending_q & ~clr_s);
    overrun_d = (overrun_q & ~{N{clr_ovr}}) | (edge_s & pending_q & ~clr_s);
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    ptr_d         = ptr_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          grant_d       = {{(N-1){1'b0}}, 1'b1} << pick_s;
          grant_id_d    = pick_s;
          grant_valid_d = 1'b1;
          state_d       = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          grant_d       = '0;
          grant_id_d    = '0;
          grant_valid_d = 1'b0;
          ptr_d         = (grant_id_q == ID_W'(N-1)) ? '0 : grant_id_q + 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      overrun_q     <= '0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      ptr_q         <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      ptr_q         <= ptr_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign pending     = pending_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with N=4: reset, latency, round-robin, overrun,
// edge-during-ack and reset-mid-grant scenarios.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] w;
  logic       ack;
  logic       clr_ovr;
  logic       grant_valid;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic [3:0] pending;
  logic [3:0] overrun;

  int checks   = 0;
  int failures = 0;

  edge_event_arbiter #(.N(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .w           (w),
    .ack         (ack),
    .clr_ovr     (clr_ovr),
    .grant_valid (grant_valid),
    .grant       (grant),
    .grant_id    (grant_id),
    .pending     (pending),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; w = 4'b0000; ack = 1'b0; clr_ovr = 1'b0;
    tick(); tick();
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", grant_valid); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_id: got %0d want 0", grant_id); end
    checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL reset_pending: got %b want 0000", pending); end
    checks++; if (overrun !== 4'b0000) begin failures++; $display("FAIL reset_overrun: got %b want 0000", overrun); end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL idle_valid cycle %0d: got %0b want 0", c, grant_valid); end
    end
    $display("reset/idle done");
  endtask

  task automatic test_single_latency();
    w = 4'b0100;
    tick();
    checks++; if (pending !== 4'b0100) begin failures++; $display("FAIL lat_pending_E0: got %b want 0100", pending); end
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL lat_valid_E0: got %0b want 0", grant_valid); end
    tick();
    checks++; if (grant_valid !== 1'b1) begin failures++; $display("FAIL lat_valid_E1: got %0b want 1", grant_valid); end
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL lat_grant_E1: got %b want 0100", grant); end
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL lat_id_E1: got %0d want 2", grant_id); end
    tick();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL lat_hold_E2: got %b want 0100", grant); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL lat_valid_E3: got %0b want 0", grant_valid); end
    checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL lat_pending_E3: got %b want 0000", pending); end
    w = 4'b0000;
    tick();
    $display("single event latency done");
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_a [4];
    logic [1:0] exp_b [4];
    exp_a = '{2'd0, 2'd1, 2'd2, 2'd3};
    exp_b = '{2'd2, 2'd3, 2'd0, 2'd1};
    reset = 1'b1; w = 4'b0000; tick(); reset = 1'b0;
    w = 4'b1111;
    tick();
    checks++; if (pending !== 4'b1111) begin failures++; $display("FAIL rr_pending: got %b want 1111", pending); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (grant_valid !== 1'b1 || grant_id !== exp_a[k]) begin failures++; $display("FAIL rr_a[%0d]: got valid=%0b id=%0d want valid=1 id=%0d", k, grant_valid, grant_id, exp_a[k]); end
      ack = 1'b1; tick(); ack = 1'b0;
      checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL rr_a_idle[%0d]: got %0b want 0", k, grant_valid); end
    end
    checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL rr_a_drain: got %b want 0000", pending); end
    // Serve channel 1 alone so the pointer lands on 2.
    w = 4'b0000; tick();
    w = 4'b0010; tick(); tick();
    checks++; if (grant_id !== 2'd1 || grant_valid !== 1'b1) begin failures++; $display("FAIL rr_setup: got valid=%0b id=%0d want valid=1 id=1", grant_valid, grant_id); end
    ack = 1'b1; tick(); ack = 1'b0;
    w = 4'b0000; tick();
    w = 4'b1111; tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (grant_valid !== 1'b1 || grant_id !== exp_b[k]) begin failures++; $display("FAIL rr_b[%0d]: got valid=%0b id=%0d want valid=1 id=%0d", k, grant_valid, grant_id, exp_b[k]); end
      ack = 1'b1; tick(); ack = 1'b0;
    end
    $display("round-robin done");
  endtask

  task automatic test_overrun();
    // Pointer is now 2; a lone channel 0 request wins and is held without ack.
    w = 4'b0000; tick();
    w = 4'b0001; tick(); tick();
    checks++; if (grant_id !== 2'd0 || grant_valid !== 1'b1) begin failures++; $display("FAIL ovr_setup: got valid=%0b id=%0d want valid=1 id=0", grant_valid, grant_id); end
    w = 4'b0011; tick();
    checks++; if (pending !== 4'b0011 || overrun !== 4'b0000) begin failures++; $display("FAIL ovr_first_edge: got pend=%b ovr=%b want pend=0011 ovr=0000", pending, overrun); end
    w = 4'b0001; tick();
    w = 4'b0011; tick();
    checks++; if (overrun !== 4'b0010) begin failures++; $display("FAIL ovr_set: got %b want 0010", overrun); end
    clr_ovr = 1'b1; w = 4'b0001; tick(); clr_ovr = 1'b0;
    checks++; if (overrun !== 4'b0000) begin failures++; $display("FAIL ovr_clear: got %b want 0000", overrun); end
    clr_ovr = 1'b1; w = 4'b0011; tick(); clr_ovr = 1'b0;
    checks++; if (overrun !== 4'b0010) begin failures++; $display("FAIL ovr_set_wins: got %b want 0010", overrun); end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++; if (pending !== 4'b0010 || grant_valid !== 1'b0) begin failures++; $display("FAIL ovr_release: got pend=%b valid=%0b want pend=0010 valid=0", pending, grant_valid); end
    tick();
    checks++; if (grant_id !== 2'd1 || grant_valid !== 1'b1) begin failures++; $display("FAIL ovr_next: got valid=%0b id=%0d want valid=1 id=1", grant_valid, grant_id); end
    $display("overrun done");
  endtask

  task automatic test_edge_during_ack();
    reset = 1'b1; w = 4'b0000; clr_ovr = 1'b0; tick(); reset = 1'b0;
    w = 4'b0001; tick(); tick();
    checks++; if (grant_id !== 2'd0 || grant_valid !== 1'b1) begin failures++; $display("FAIL eda_setup: got valid=%0b id=%0d want valid=1 id=0", grant_valid, grant_id); end
    w = 4'b0000; tick();
    w = 4'b0001; ack = 1'b1; tick(); ack = 1'b0;
    checks++; if (pending !== 4'b0001) begin failures++; $display("FAIL eda_pending: got %b want 0001", pending); end
    checks++; if (overrun !== 4'b0000) begin failures++; $display("FAIL eda_overrun: got %b want 0000", overrun); end
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL eda_idle: got %0b want 0", grant_valid); end
    tick();
    checks++; if (grant_id !== 2'd0 || grant_valid !== 1'b1) begin failures++; $display("FAIL eda_regrant: got valid=%0b id=%0d want valid=1 id=0", grant_valid, grant_id); end
    $display("edge during ack done");
  endtask

  task automatic test_reset_mid_grant();
    reset = 1'b1; w = 4'b0000; tick(); reset = 1'b0;
    w = 4'b1010; tick(); tick();
    checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL rmg_first: got %0d want 1", grant_id); end
    ack = 1'b1; tick(); ack = 1'b0;
    w = 4'b1000; tick();
    checks++; if (grant_id !== 2'd3 || grant_valid !== 1'b1) begin failures++; $display("FAIL rmg_second: got valid=%0b id=%0d want valid=1 id=3", grant_valid, grant_id); end
    w = 4'b1010; tick();
    checks++; if (pending !== 4'b1010) begin failures++; $display("FAIL rmg_pending: got %b want 1010", pending); end
    reset = 1'b1; tick();
    checks++; if ({grant_valid, grant, grant_id, pending, overrun} !== 15'd0) begin failures++; $display("FAIL rmg_reset: got valid=%0b grant=%b id=%0d pend=%b ovr=%b want all 0", grant_valid, grant, grant_id, pending, overrun); end
    reset = 1'b0; tick();
    checks++; if (pending !== 4'b1010) begin failures++; $display("FAIL rmg_held_edge: got %b want 1010", pending); end
    tick();
    checks++; if (grant_id !== 2'd1 || grant_valid !== 1'b1) begin failures++; $display("FAIL rmg_ptr0: got valid=%0b id=%0d want valid=1 id=1", grant_valid, grant_id); end
    $display("reset mid-grant done");
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_round_robin();
    test_overrun();
    test_edge_during_ack();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
